md_stall_ctrl: RTL and testbench

- Central stall/freeze scheduler for the 5-stage pipeline.
- Drives the stall_data and busy[2:0] controls consumed by every pipeline register.
- Sequences the multi-cycle multiply/divide unit (latency counter, HI/LO write pulse).
- Detects load-use hazards in D, so F/D hold and E receives a bubble.

---
 rtl/md_stall_ctrl_if.sv | 33 +++
 rtl/md_stall_ctrl.sv | 97 +++++++++
 tb/tb_md_stall_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/md_stall_ctrl_if.sv
// Pipeline-side signal bundle for md_stall_ctrl: hazard inputs from D/E, MD start, and stall/freeze outputs.
interface md_stall_ctrl_if #(
    parameter int CNT_W = 4
);
    logic             md_start_e;
    logic             md_op_e;
    logic             md_use_d;
    logic [4:0]       rs_d;
    logic [4:0]       rt_d;
    logic             use_rs_d;
    logic             use_rt_d;
    logic             memread_e;
    logic [4:0]       wreg_e;
    logic             mem_wait;
    logic             stall_data;
    logic             flush_e;
    logic [2:0]       busy;
    logic             hilo_we;
    logic [CNT_W-1:0] md_cnt;
    logic             md_err;

    modport master (
        output md_start_e, md_op_e, md_use_d, rs_d, rt_d, use_rs_d, use_rt_d,
               memread_e, wreg_e, mem_wait,
        input  stall_data, flush_e, busy, hilo_we, md_cnt, md_err
    );

    modport slave (
        input  md_start_e, md_op_e, md_use_d, rs_d, rt_d, use_rs_d, use_rt_d,
               memread_e, wreg_e, mem_wait,
        output stall_data, flush_e, busy, hilo_we, md_cnt, md_err
    );
endinterface

// File: rtl/md_stall_ctrl.sv
// Stall/freeze scheduler: multiply/divide sequencing plus load-use and HI/LO hazard detection.
// Define MD_OVERLAP_EN to let independent instructions flow while the MD unit runs.
//
// state | meaning
// IDLE  | MD unit free, accepts md_start_e
// MULT  | multiply in progress, md_cnt counting down
// DIV   | divide in progress, md_cnt counting down
// DONE  | result ready, hilo_we asserted for this cycle
module md_stall_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    md_stall_ctrl_if.slave md
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] MULT_INIT = CNT_W'(MULT_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_INIT  = CNT_W'(DIV_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             err, err_nxt;
    logic             load_use;
    logic             md_hz;
    logic [1:0]       md_run;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= CNT_ZERO;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            err   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        err_nxt   = err;
        case (state)
            IDLE: begin
                if (md.md_start_e) begin
                    state_nxt = md.md_op_e ? DIV : MULT;
                    cnt_nxt   = md.md_op_e ? DIV_INIT : MULT_INIT;
                end
            end
            MULT, DIV: begin
                if (cnt == CNT_ONE) begin
                    state_nxt = DONE;
                    cnt_nxt   = CNT_ZERO;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            DONE: state_nxt = IDLE;
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = CNT_ZERO;
            end
        endcase
        // A start seen outside IDLE is dropped; flag it until reset.
        if (state != IDLE && md.md_start_e)
            err_nxt = 1'b1;
    end

    assign load_use = md.memread_e && (md.wreg_e != 5'd0) &&
                      ((md.use_rs_d && (md.rs_d == md.wreg_e)) ||
                       (md.use_rt_d && (md.rt_d == md.wreg_e)));

    assign md_hz = md.md_use_d && ((state != IDLE) || md.md_start_e);

`ifdef MD_OVERLAP_EN
    assign md_run = 2'b00;
`else
    assign md_run = {state == DIV, state == MULT};
`endif

    assign md.busy       = {md.mem_wait, md_run};
    assign md.stall_data = load_use || md_hz;
    assign md.flush_e    = md.stall_data && (md.busy == 3'b000);
    assign md.hilo_we    = (state == DONE);
    assign md.md_cnt     = cnt;
    assign md.md_err     = err;
endmodule

// File: tb/tb_md_stall_ctrl.sv
// Randomized self-checking bench for md_stall_ctrl against an occupancy-count reference model.
module tb_md_stall_ctrl;
    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;
    localparam int CNT_W    = 4;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;

    // Reference model: occ = cycles left until the MD unit is free again.
    int   occ;
    bit   op_div;
    bit   err_m;

    md_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

    md_stall_ctrl #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .md      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        bit       running, lu, hz, stall;
        bit [2:0] busy_e;
        int       cnt_e;
        running = (occ > 1);
        cnt_e   = running ? occ - 1 : 0;
`ifdef MD_OVERLAP_EN
        busy_e  = {bus.mem_wait, 2'b00};
`else
        busy_e  = {bus.mem_wait, running && op_div, running && !op_div};
`endif
        lu = bus.memread_e && (bus.wreg_e != 0) &&
             ((bus.use_rs_d && bus.rs_d == bus.wreg_e) || (bus.use_rt_d && bus.rt_d == bus.wreg_e));
        hz    = bus.md_use_d && (occ > 0 || bus.md_start_e);
        stall = lu || hz;
        chk("stall_data", 32'(bus.stall_data), 32'(stall));
        chk("flush_e",    32'(bus.flush_e),    32'(stall && busy_e == 3'b000));
        chk("busy",       32'(bus.busy),       32'(busy_e));
        chk("hilo_we",    32'(bus.hilo_we),    32'(occ == 1));
        chk("md_cnt",     32'(bus.md_cnt),     32'(cnt_e));
        chk("md_err",     32'(bus.md_err),     32'(err_m));
    endtask

    task automatic run_cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        if (occ > 0) begin
            occ--;
            if (bus.md_start_e) err_m = 1'b1;
        end else if (bus.md_start_e) begin
            occ    = bus.md_op_e ? DIV_LAT : MULT_LAT;
            op_div = bus.md_op_e;
        end
        #1;
    endtask

    task automatic idle_inputs();
        bus.md_start_e = 1'b0;
        bus.md_op_e    = 1'b0;
        bus.md_use_d   = 1'b0;
        bus.rs_d       = 5'd0;
        bus.rt_d       = 5'd0;
        bus.use_rs_d   = 1'b0;
        bus.use_rt_d   = 1'b0;
        bus.memread_e  = 1'b0;
        bus.wreg_e     = 5'd0;
        bus.mem_wait   = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        occ     = 0;
        err_m   = 1'b0;
        #1;
        check_outputs();
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        occ     = 0;
        op_div  = 1'b0;
        err_m   = 1'b0;
        reset_n = 1'b0;
        idle_inputs();
        #12;
        check_outputs();
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Multiply: occupancy MULT_LAT+1 cycles.
        bus.md_start_e = 1'b1;
        run_cycle();
        bus.md_start_e = 1'b0;
        for (int i = 0; i < MULT_LAT + 1; i++) run_cycle();

        // Divide with dependent mfhi in D throughout.
        bus.md_start_e = 1'b1;
        bus.md_op_e    = 1'b1;
        bus.md_use_d   = 1'b1;
        run_cycle();
        bus.md_start_e = 1'b0;
        for (int i = 0; i < DIV_LAT + 1; i++) run_cycle();
        chk("div_stall_released", 32'(bus.stall_data), 32'(0));
        idle_inputs();

        // Load-use hit, then wreg_e=0 and use_rs_d=0 misses.
        bus.memread_e = 1'b1;
        bus.wreg_e    = 5'd8;
        bus.rs_d      = 5'd8;
        bus.use_rs_d  = 1'b1;
        run_cycle();
        chk("lu_hit_stall", 32'(bus.stall_data), 32'(1));
        bus.wreg_e = 5'd0;
        bus.rs_d   = 5'd0;
        run_cycle();
        bus.wreg_e   = 5'd8;
        bus.rs_d     = 5'd8;
        bus.use_rs_d = 1'b0;
        run_cycle();
        idle_inputs();

        // Collision during multiply at md_cnt=3.
        bus.md_start_e = 1'b1;
        run_cycle();
        bus.md_start_e = 1'b0;
        run_cycle();
        bus.md_start_e = 1'b1;
        bus.md_op_e    = 1'b1;
        run_cycle();
        idle_inputs();
        for (int i = 0; i < MULT_LAT + 2; i++) run_cycle();
        chk("err_sticky", 32'(bus.md_err), 32'(1));

        // Reset mid-divide with md_cnt=6.
        do_reset();
        @(posedge clk);
        #1;
        bus.md_start_e = 1'b1;
        bus.md_op_e    = 1'b1;
        run_cycle();
        bus.md_start_e = 1'b0;
        for (int i = 0; i < 3; i++) run_cycle();
        chk("pre_reset_cnt", 32'(bus.md_cnt), 32'(6));
        do_reset();
        @(posedge clk);
        #1;
        run_cycle();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            bus.md_start_e = (occ == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
            bus.md_op_e    = 1'($urandom);
            bus.md_use_d   = ($urandom_range(0, 3) == 0);
            bus.rs_d       = 5'($urandom_range(0, 3));
            bus.rt_d       = 5'($urandom_range(0, 3));
            bus.use_rs_d   = 1'($urandom);
            bus.use_rt_d   = 1'($urandom);
            bus.memread_e  = 1'($urandom);
            bus.wreg_e     = 5'($urandom_range(0, 3));
            bus.mem_wait   = ($urandom_range(0, 4) == 0);
            if (n % 400 == 399) begin
                do_reset();
                @(posedge clk);
                #1;
            end
            run_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
